// File: rtl/fmap_bram_loader_pkg.sv
// Shared definitions for the feature-map BRAM loader: default geometry,
// FSM state encoding and the clogb2 width helper.
package fmap_bram_loader_pkg;

  localparam int DEFAULT_IN_WIDTH    = 8;
  localparam int DEFAULT_KERNEL_SIZE = 5;
  localparam int DEFAULT_IMAGE       = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of bits needed to hold the value itself (clogb2(32) = 6).
  function automatic int clogb2(input int value);
    int v;
    int bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/fmap_bram_loader_pixel_packer.sv
// Packs KERNEL_SIZE consecutive pixels into one word. Lane 0 sits in the
// least significant bits. word_valid/word are combinational and flag the
// push that completes a word, so the caller can register the write port
// one cycle after the last pixel is accepted.
module fmap_bram_loader_pixel_packer
  import fmap_bram_loader_pkg::*;
#(
  parameter int IN_WIDTH    = DEFAULT_IN_WIDTH,
  parameter int KERNEL_SIZE = DEFAULT_KERNEL_SIZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            push,
  input  logic [IN_WIDTH-1:0]             pixel,
  output logic                            word_valid,
  output logic [KERNEL_SIZE*IN_WIDTH-1:0] word
);

  localparam int CNT_W = clogb2(KERNEL_SIZE);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(KERNEL_SIZE - 1);

  logic [IN_WIDTH-1:0] lane_q [KERNEL_SIZE];
  logic [CNT_W-1:0]    pix_cnt_q;

  // Lane buffer and lane counter; a clear restarts packing from lane 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pix_cnt_q <= '0;
      for (int k = 0; k < KERNEL_SIZE; k++) begin
        lane_q[k] <= '0;
      end
    end else if (push) begin
      lane_q[pix_cnt_q] <= pixel;
      if (pix_cnt_q == LAST_LANE) begin
        pix_cnt_q <= '0;
      end else begin
        pix_cnt_q <= pix_cnt_q + CNT_W'(1);
      end
    end
  end

  // Assemble the word with the incoming pixel substituted into its lane.
  always_comb begin
    word       = '0;
    word_valid = push && (pix_cnt_q == LAST_LANE);
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      if (pix_cnt_q == CNT_W'(k)) begin
        word[k*IN_WIDTH +: IN_WIDTH] = pixel;
      end else begin
        word[k*IN_WIDTH +: IN_WIDTH] = lane_q[k];
      end
    end
  end

endmodule

// File: rtl/fmap_bram_loader.sv
// Writer side of the feature-map BRAM load interface. Streams pixels in
// with a valid/ready handshake, packs them into KERNEL_SIZE-pixel words,
// writes IMAGE words at addresses 0..IMAGE-1 and pulses load_down once.
//
// Handshake: a pixel transfers on a rising edge where pixel_valid and
// pixel_ready are both high; pixel_ready does not depend on pixel_valid and
// the source may hold or drop pixel_valid freely (a low valid simply stalls).
//
// DONE spans two cycles: the final write cycle (pixel_ready already low,
// busy still high) and then the load_down cycle (busy low).
module fmap_bram_loader
  import fmap_bram_loader_pkg::*;
#(
  parameter int IN_WIDTH    = DEFAULT_IN_WIDTH,
  parameter int KERNEL_SIZE = DEFAULT_KERNEL_SIZE,
  parameter int IMAGE       = DEFAULT_IMAGE,
  parameter int ADDR_WIDTH  = clogb2(IMAGE)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            pixel_valid,
  input  logic [IN_WIDTH-1:0]             nextPixel,
  output logic                            pixel_ready,
  output logic                            bram_select_en,
  output logic [ADDR_WIDTH-1:0]           bram_addr_f,
  output logic [KERNEL_SIZE*IN_WIDTH-1:0] bram_data_f,
  output logic                            load_down,
  output logic                            busy,
  output state_t                          dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMAGE - 1);

  state_t                          state_q;
  state_t                          state_d;
  logic [ADDR_WIDTH-1:0]           word_cnt_q;
  logic                            transfer;
  logic                            clear;
  logic                            word_valid;
  logic                            last_word;
  logic [KERNEL_SIZE*IN_WIDTH-1:0] word;

  assign transfer  = pixel_valid && pixel_ready;
  assign clear     = (state_q == ST_IDLE) && start;
  assign last_word = word_valid && (word_cnt_q == LAST_ADDR);

  fmap_bram_loader_pixel_packer #(
    .IN_WIDTH    (IN_WIDTH),
    .KERNEL_SIZE (KERNEL_SIZE)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .push       (transfer),
    .pixel      (nextPixel),
    .word_valid (word_valid),
    .word       (word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE waits out the final write strobe before returning.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)           state_d = ST_FILL;
      ST_FILL: if (last_word)       state_d = ST_DONE;
      ST_DONE: if (!bram_select_en) state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    pixel_ready = (state_q == ST_FILL);
    load_down   = (state_q == ST_DONE) && !bram_select_en;
    busy        = (state_q == ST_FILL) || ((state_q == ST_DONE) && bram_select_en);
    dbg_state   = state_q;
  end

  // Write port and word counter; address/data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_select_en <= 1'b0;
      bram_addr_f    <= '0;
      bram_data_f    <= '0;
      word_cnt_q     <= '0;
    end else begin
      bram_select_en <= word_valid;
      if (clear) begin
        word_cnt_q <= '0;
      end
      if (word_valid) begin
        bram_addr_f <= word_cnt_q;
        bram_data_f <= word;
        if (!last_word) begin
          word_cnt_q <= word_cnt_q + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fmap_bram_loader.sv
// Directed/randomized bench for fmap_bram_loader. Expected words, addresses
// and write cycles come from the pixel list and the acceptance cycles of the
// last pixel in each word.
module tb_fmap_bram_loader;
  import fmap_bram_loader_pkg::*;

  localparam int W   = 8;
  localparam int K   = 5;
  localparam int IMG = 32;
  localparam int AW  = 6;
  localparam int DW  = W * K;
  localparam int NPIX = IMG * K;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          pixel_valid = 1'b0;
  logic [W-1:0]  nextPixel = '0;
  logic          pixel_ready;
  logic          bram_select_en;
  logic [AW-1:0] bram_addr_f;
  logic [DW-1:0] bram_data_f;
  logic          load_down;
  logic          busy;
  state_t        dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [W-1:0]  pix_q[$];
  logic [DW-1:0] exp_q[$];
  int            acc_cyc_q[$];
  logic [AW-1:0] got_addr_q[$];
  logic [DW-1:0] got_data_q[$];
  int            got_cyc_q[$];
  int            ld_cyc_q[$];
  logic          ld_busy_q[$];

  fmap_bram_loader #(
    .IN_WIDTH    (W),
    .KERNEL_SIZE (K),
    .IMAGE       (IMG)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pixel_valid    (pixel_valid),
    .nextPixel      (nextPixel),
    .pixel_ready    (pixel_ready),
    .bram_select_en (bram_select_en),
    .bram_addr_f    (bram_addr_f),
    .bram_data_f    (bram_data_f),
    .load_down      (load_down),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe writes and completion pulses between active edges.
  always @(negedge clk) begin
    if (bram_select_en === 1'b1) begin
      got_addr_q.push_back(bram_addr_f);
      got_data_q.push_back(bram_data_f);
      got_cyc_q.push_back(cyc);
    end
    if (load_down === 1'b1) begin
      ld_cyc_q.push_back(cyc);
      ld_busy_q.push_back(busy);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    got_addr_q.delete();
    got_data_q.delete();
    got_cyc_q.delete();
    ld_cyc_q.delete();
    ld_busy_q.delete();
    acc_cyc_q.delete();
  endtask

  // mode 0: pixel i = i mod 256; mode 1: random bytes.
  task automatic build_pixels(input int mode);
    pix_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      if (mode == 0) pix_q.push_back(W'(i % 256));
      else           pix_q.push_back(W'($urandom_range(0, 255)));
    end
  endtask

  // Reference model: word w holds pixels 5w..5w+4, first pixel in the low byte.
  task automatic build_model();
    logic [DW-1:0] wd;
    exp_q.delete();
    for (int w = 0; w < IMG; w++) begin
      wd = '0;
      for (int k = 0; k < K; k++) wd[k*W +: W] = pix_q[w*K + k];
      exp_q.push_back(wd);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, pixel_ready, 0);
    chk({tag, "_sel"},   bram_select_en, 0);
    chk({tag, "_addr"},  bram_addr_f, 0);
    chk({tag, "_data"},  bram_data_f, 0);
    chk({tag, "_ld"},    load_down, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  task automatic start_load(input string tag);
    @(negedge clk);
    start = 1'b1;
    pixel_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_state_fill"}, dbg_state, ST_FILL);
  endtask

  // Offer one pixel at successive negedges until the loader is ready.
  task automatic send_pixel(input logic [W-1:0] p, input bit pulse, output int acc, output bit ok);
    ok = 1'b0;
    acc = 0;
    for (int t = 0; t < 16 && !ok; t++) begin
      @(negedge clk);
      pixel_valid = 1'b1;
      nextPixel = p;
      start = pulse;
      if (pixel_ready === 1'b1) begin
        ok = 1'b1;
        acc = cyc;
      end
    end
  endtask

  task automatic send_stream(input int n, input int gap_every, input int gap_len,
                             input int pulse_idx, input bit expect_end);
    bit ok;
    int c;
    for (int i = 0; i < n; i++) begin
      if (gap_every > 0 && i > 0 && (i % gap_every) == 0) begin
        repeat (gap_len) begin
          @(negedge clk);
          pixel_valid = 1'b0;
          start = 1'b0;
          nextPixel = W'($urandom_range(0, 255));
        end
      end
      send_pixel(pix_q[i], (i == pulse_idx), c, ok);
      if (!ok) begin
        chk($sformatf("pixel_accept_%0d", i), ok, 1'b1);
        break;
      end
      acc_cyc_q.push_back(c);
    end
    if (expect_end) begin
      @(negedge clk);
      pixel_valid = 1'b1;
      nextPixel = 8'h5A;
      start = 1'b0;
      chk("ready_after_last", pixel_ready, 0);
      @(negedge clk);
      chk("ready_after_last2", pixel_ready, 0);
      pixel_valid = 1'b0;
    end
  endtask

  task automatic check_load(input string tag);
    int n;
    for (int t = 0; t < 50 && ld_cyc_q.size() == 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_ld_pulses"}, ld_cyc_q.size(), 1);
    chk({tag, "_n_writes"}, got_addr_q.size(), IMG);
    n = (got_addr_q.size() < IMG) ? got_addr_q.size() : IMG;
    for (int w = 0; w < n; w++) begin
      chk($sformatf("%s_addr%0d", tag, w), got_addr_q[w], AW'(w));
      chk($sformatf("%s_data%0d", tag, w), got_data_q[w], exp_q[w]);
      if (acc_cyc_q.size() > w*K + K - 1)
        chk($sformatf("%s_wcyc%0d", tag, w), got_cyc_q[w], acc_cyc_q[w*K + K - 1] + 1);
    end
    if (ld_cyc_q.size() > 0 && acc_cyc_q.size() == NPIX) begin
      chk({tag, "_ld_cycle"}, ld_cyc_q[0], acc_cyc_q[NPIX-1] + 2);
      chk({tag, "_ld_busy"}, ld_busy_q[0], 0);
    end
    chk({tag, "_hold_addr"}, bram_addr_f, AW'(IMG - 1));
    chk({tag, "_hold_data"}, bram_data_f, exp_q[IMG-1]);
    chk({tag, "_sel_low"}, bram_select_en, 0);
    chk({tag, "_end_state"}, dbg_state, ST_IDLE);
    chk({tag, "_end_busy"}, busy, 0);
  endtask

  // Bound the whole run in case the DUT never finishes a load.
  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset_init");
    rst = 1'b0;

    // Full load, pixel = index mod 256, continuous valid
    build_pixels(0);
    build_model();
    clear_obs();
    start_load("full");
    send_stream(NPIX, 0, 0, -1, 1'b1);
    check_load("full");
    if (got_data_q.size() == IMG) begin
      chk("full_addr0_const", got_data_q[0], 40'h0403020100);
      chk("full_addr31_const", got_data_q[IMG-1], 40'h9F9E9D9C9B);
      for (int w = 1; w < IMG; w++)
        chk($sformatf("full_spacing%0d", w), got_cyc_q[w] - got_cyc_q[w-1], K);
    end

    // Same data with 3-cycle valid gaps every 2 pixels
    clear_obs();
    start_load("gap");
    send_stream(NPIX, 2, 3, -1, 1'b1);
    check_load("gap");

    // Signed pixels at the head of a random stream
    build_pixels(1);
    pix_q[0] = 8'hFF;
    pix_q[1] = 8'h80;
    pix_q[2] = 8'h7F;
    pix_q[3] = 8'h00;
    pix_q[4] = 8'h01;
    build_model();
    clear_obs();
    start_load("signed");
    send_stream(NPIX, 0, 0, -1, 1'b1);
    check_load("signed");
    if (got_data_q.size() > 0) chk("signed_word0_const", got_data_q[0], 40'h01007F80FF);

    // Start pulsed during word 10 is ignored
    build_pixels(1);
    build_model();
    clear_obs();
    start_load("busy_start");
    send_stream(NPIX, 0, 0, 10*K, 1'b1);
    check_load("busy_start");

    // Reset in the middle of word 17
    build_pixels(1);
    build_model();
    clear_obs();
    start_load("abort");
    send_stream(17*K + 2, 0, 0, -1, 1'b0);
    chk("abort_writes_before_reset", got_addr_q.size(), 17);
    @(negedge clk);
    rst = 1'b1;
    clear_obs();
    repeat (3) @(negedge clk);
    check_idle("reset_mid");
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      pixel_valid = 1'b1;
      nextPixel = W'($urandom_range(0, 255));
      chk("post_reset_ready", pixel_ready, 0);
    end
    @(negedge clk);
    pixel_valid = 1'b0;
    chk("post_reset_no_writes", got_addr_q.size(), 0);
    chk("post_reset_no_ld", ld_cyc_q.size(), 0);

    // Fresh load after the abort restarts at address 0
    build_pixels(1);
    build_model();
    clear_obs();
    start_load("restart");
    send_stream(NPIX, 0, 0, -1, 1'b1);
    check_load("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
